// File: rtl/sext_stream_unpacker_pkg.sv
// Shared types for the operand sign-extension stream unpacker.
// Holds the FSM state enum and the lane-count helper.
package ai_core_sext_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } sext_unp_state_t;

  function automatic int lanes_f(input int word_w, input int in_size);
    return word_w / in_size;
  endfunction

endpackage

// File: rtl/sext_stream_unpacker_ext.sv
// Sign extender: replicates the MSB of i_x up to OUT_W bits.
// Ports: i_x (IN_W) in, o_y (OUT_W) out.
module sign_extender #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i_x,
  output logic [OUT_W-1:0] o_y
);

  if (OUT_W > IN_W) begin : g_ext
    assign o_y = {{(OUT_W-IN_W){i_x[IN_W-1]}}, i_x};
  end else begin : g_trunc
    assign o_y = i_x[OUT_W-1:0];
  end

endmodule

// File: rtl/sext_stream_unpacker.sv
// Unpacks IN_SIZE-bit lanes of a packed word, one per cycle, extended to OUT_SIZE.
// Ports: clk_i/rst_i, in_* word stream (valid/ready), out_* element stream, busy_o.
module sext_stream_unpacker
  import ai_core_sext_pkg::*;
#(
  parameter int   WORD_W   = 32,
  parameter int   IN_SIZE  = 8,
  parameter int   OUT_SIZE = 16,
  localparam int  LANES    = lanes_f(WORD_W, IN_SIZE),
  localparam int  CW       = $clog2(LANES + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WORD_W-1:0]   in_data_i,
  input  logic [CW-1:0]       in_count_i,
  input  logic                in_last_i,
  input  logic                in_signed_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OUT_SIZE-1:0] out_data_o,
  output logic                out_last_o,
  output logic                busy_o
);

  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  if ((WORD_W % IN_SIZE) != 0) begin : g_bad_word
    $error("WORD_W must be a multiple of IN_SIZE");
  end
  if (OUT_SIZE <= IN_SIZE) begin : g_bad_out
    $error("OUT_SIZE must exceed IN_SIZE");
  end

  sext_unp_state_t     r_state;
  sext_unp_state_t     w_state_nxt;
  logic [WORD_W-1:0]   r_data;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_idx;
  logic                r_last;
  logic                r_signed;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_final;
  logic                w_fire;
  logic                w_load;
  logic [CW-1:0]       w_cnt_clamp;
  logic [IN_SIZE-1:0]  w_lane;
  logic [IN_SIZE:0]    w_ext_in;
  logic [OUT_SIZE-1:0] w_ext_out;

  // 0 or an out-of-range count means a full word
  assign w_cnt_clamp = ((in_count_i == '0) || (in_count_i > LANES_C))
                     ? LANES_C : in_count_i;

  assign w_final = (r_idx == (r_count - CW'(1)));
  assign w_fire  = w_out_valid & out_ready_i;
  assign w_load  = in_valid_i & w_in_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid_i) w_state_nxt = EMIT;
      end
      EMIT: begin
        w_out_valid = 1'b1;
        // final lane leaving: the input may refill in the same cycle
        if (out_ready_i && w_final) begin
          w_in_ready = 1'b1;
          if (!in_valid_i) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data   <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_last   <= 1'b0;
      r_signed <= 1'b0;
    end else if (w_load) begin
      r_data   <= in_data_i;
      r_count  <= w_cnt_clamp;
      r_idx    <= '0;
      r_last   <= in_last_i;
      r_signed <= in_signed_i;
    end else if (w_fire && !w_final) begin
      r_idx    <= r_idx + CW'(1);
    end
  end

  always_comb begin
    w_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      if (r_idx == CW'(k)) w_lane = r_data[k*IN_SIZE +: IN_SIZE];
    end
  end

  // extra top bit turns one sign extender into sign- or zero-extension
  assign w_ext_in = {r_signed & w_lane[IN_SIZE-1], w_lane};

  sign_extender #(IN_SIZE + 1, OUT_SIZE) u_ext (
    .i_x (w_ext_in),
    .o_y (w_ext_out)
  );

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign out_data_o  = w_out_valid ? w_ext_out : '0;
  assign out_last_o  = w_out_valid & r_last & w_final;
  assign busy_o      = (r_state == EMIT);

endmodule
